// File: rtl/seq_ctrl_pkg.sv
// Shared types and helpers for the serial pattern-detection controller.
package seq_ctrl_pkg;

    localparam int unsigned DefaultMaxLen = 8;
    localparam int unsigned DefaultCntW   = 8;
    localparam int unsigned DefaultWinW   = 16;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StDone
    } state_e;

    // Effective pattern length: 0 behaves as 1, oversize values saturate at max_len.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked pattern comparator.
module seq_match_core #(
    parameter  int unsigned MAX_LEN = 8,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               w,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    output logic               match,
    output logic               full
);

    localparam int unsigned MW = MAX_LEN + 1;

    logic [MAX_LEN-1:0] hist_q, hist_next, mask;
    logic [MW-1:0]      mask_wide;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W:0]     fill_inc;

    // Compare against the history as it will look once the incoming bit is shifted in.
    always_comb begin
        hist_next = {hist_q[MAX_LEN-2:0], w};
        mask_wide = (MW'(1) << len) - MW'(1);
        mask      = mask_wide[MAX_LEN-1:0];
        fill_inc  = {1'b0, fill_q} + (LEN_W + 1)'(1);
        full      = shift_en && (fill_inc >= {1'b0, len});
        match     = full && (((hist_next ^ pattern) & mask) == '0);
    end

    // Clear wins over shift so a non-overlapping match discards its own bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_next;
            fill_q <= full ? len : fill_q + LEN_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Session controller: arms, runs and terminates serial pattern detection.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter  int unsigned MAX_LEN = DefaultMaxLen,
    parameter  int unsigned CNT_W   = DefaultCntW,
    parameter  int unsigned WIN_W   = DefaultWinW,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_limit,
    input  logic [WIN_W-1:0]   cfg_window,
    input  logic               start,
    input  logic               abort,
    input  logic               w,
    input  logic               w_valid,
    output logic               z,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   match_cnt
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q, len_eff;
    logic               overlap_q;
    logic [CNT_W-1:0]   limit_q;
    logic [WIN_W-1:0]   window_q;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic               timeout_q, timeout_d;
    logic               z_q, z_d;
    logic               load, accept, core_clear, core_match, core_full;

    assign len_eff = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));

    seq_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .clear    (core_clear),
        .w        (w),
        .len      (len_q),
        .pattern  (pattern_q),
        .match    (core_match),
        .full     (core_full)
    );

    // Next-state, counters and termination; abort always beats start and data.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        timeout_d   = timeout_q;
        z_d         = 1'b0;
        load        = 1'b0;
        accept      = 1'b0;
        core_clear  = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (start) begin
                    load        = 1'b1;
                    core_clear  = 1'b1;
                    match_cnt_d = '0;
                    win_cnt_d   = '0;
                    timeout_d   = 1'b0;
                    state_d     = StFill;
                end
            end
            StFill, StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (w_valid) begin
                    accept    = 1'b1;
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    if (core_match) begin
                        z_d         = 1'b1;
                        match_cnt_d = (match_cnt_q == {CNT_W{1'b1}}) ? match_cnt_q
                                                                     : match_cnt_q + CNT_W'(1);
                    end
                    if (core_match && (limit_q != '0) && (match_cnt_d == limit_q)) begin
                        state_d   = StDone;
                        timeout_d = 1'b0;
                    end else if ((window_q != '0) && (win_cnt_d == window_q)) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                    end else if (core_match && !overlap_q) begin
                        core_clear = 1'b1;
                        state_d    = StFill;
                    end else if (core_full) begin
                        state_d = StRun;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Session state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            timeout_q   <= timeout_d;
            z_q         <= z_d;
        end
    end

    // Configuration snapshot taken only when a session is armed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q <= '0;
            len_q     <= LEN_W'(1);
            overlap_q <= 1'b0;
            limit_q   <= '0;
            window_q  <= '0;
        end else if (load) begin
            pattern_q <= cfg_pattern;
            len_q     <= len_eff;
            overlap_q <= cfg_overlap;
            limit_q   <= cfg_limit;
            window_q  <= cfg_window;
        end
    end

    assign z         = z_q;
    assign busy      = (state_q == StFill) || (state_q == StRun);
    assign done      = (state_q == StDone);
    assign timeout   = timeout_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl with a queue-based reference model.
module tb_seq_detect_ctrl;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned WIN_W   = 16;
    localparam int unsigned LEN_W   = 4;

    logic               clk, rst;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_limit;
    logic [WIN_W-1:0]   cfg_window;
    logic               start, abort, w, w_valid;
    logic               z, busy, done, timeout;
    logic [CNT_W-1:0]   match_cnt;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W),
        .WIN_W   (WIN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_limit   (cfg_limit),
        .cfg_window  (cfg_window),
        .start       (start),
        .abort       (abort),
        .w           (w),
        .w_valid     (w_valid),
        .z           (z),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .match_cnt   (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             z;
        logic             busy;
        logic             done;
        logic             timeout;
        logic [CNT_W-1:0] cnt;
    } out_t;

    out_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc_n  = 0;

    // Reference model state
    bit               m_active, m_done, m_timeout, m_z;
    int               m_cnt, m_win;
    bit               m_bits[$];
    int               m_len, m_lim, m_window;
    logic [MAX_LEN-1:0] m_pat;
    bit               m_ovl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active  = 0;
        m_done    = 0;
        m_timeout = 0;
        m_z       = 0;
        m_cnt     = 0;
        m_win     = 0;
        m_bits.delete();
    endfunction

    // One clock edge of the behavioural model, using the inputs presented at that edge.
    function automatic void model_edge();
        m_z = 0;
        if (m_active) begin
            if (abort) begin
                m_active = 0;
            end else if (w_valid) begin
                bit hit;
                m_bits.push_back(w);
                if (m_bits.size() > 16) void'(m_bits.pop_front());
                m_win++;
                hit = (m_bits.size() >= m_len);
                if (hit) begin
                    for (int i = 0; i < m_len; i++)
                        if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 0;
                end
                if (hit) begin
                    m_z = 1;
                    if (m_cnt < 255) m_cnt++;
                    if (!m_ovl) m_bits.delete();
                end
                if (hit && m_lim != 0 && m_cnt == m_lim) begin
                    m_active  = 0;
                    m_done    = 1;
                    m_timeout = 0;
                end else if (m_window != 0 && m_win == m_window) begin
                    m_active  = 0;
                    m_done    = 1;
                    m_timeout = 1;
                end
            end
        end else begin
            if (abort) begin
                m_done = 0;
            end else if (start) begin
                m_len     = (cfg_len == 0) ? 1 : (cfg_len > MAX_LEN) ? MAX_LEN : int'(cfg_len);
                m_pat     = cfg_pattern;
                m_ovl     = cfg_overlap;
                m_lim     = int'(cfg_limit);
                m_window  = int'(cfg_window);
                m_active  = 1;
                m_done    = 0;
                m_cnt     = 0;
                m_win     = 0;
                m_timeout = 0;
                m_bits.delete();
            end
        end
    endfunction

    // One clock cycle of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input bit st, input bit ab, input bit wv, input bit wb);
        out_t e;
        start   = st;
        abort   = ab;
        w_valid = wv;
        w       = wb;
        @(posedge clk);
        if (rst) model_edge();
        e = {m_z, m_active, m_done, m_timeout, CNT_W'(m_cnt)};
        exp_q.push_back(e);
        #1;
        start   = 1'b0;
        abort   = 1'b0;
        w_valid = 1'b0;
    endtask

    task automatic scramble_cfg();
        cfg_pattern = MAX_LEN'($urandom);
        cfg_len     = LEN_W'($urandom);
        cfg_overlap = 1'($urandom);
        cfg_limit   = CNT_W'($urandom_range(0, 4));
        cfg_window  = ($urandom_range(0, 1) == 0) ? '0 : WIN_W'($urandom_range(1, 30));
    endtask

    // Arm a session, then disturb cfg_* to show it is ignored mid-session.
    task automatic begin_session(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl,
                                 input int lim, input int win);
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        cfg_limit   = CNT_W'(lim);
        cfg_window  = WIN_W'(win);
        cyc(1, 0, 0, 0);
        scramble_cfg();
    endtask

    // Feed n bits of v, oldest first (MSB of the n-bit field first).
    task automatic feed(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(0, 0, 1, v[i]);
    endtask

    // Monitor: pop one expectation per cycle and compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            out_t e, a;
            e = exp_q.pop_front();
            a = {z, busy, done, timeout, match_cnt};
            cyc_n++;
            check($sformatf("cycle %0d outputs {z,busy,done,timeout,cnt}", cyc_n), 32'(a), 32'(e));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        start = 1'b0; abort = 1'b0; w = 1'b0; w_valid = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_limit = '0; cfg_window = '0;
        model_reset();
        #1;
        check("reset outputs", 32'({z, busy, done, timeout, match_cnt}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 1, 1);

        // Overlap, 1111: three matches, still busy
        begin_session(8'b1111, 4, 1, 0, 0);
        feed(32'b0011111101, 10);
        check("overlap match_cnt", 32'(match_cnt), 32'd3);
        check("overlap busy", 32'(busy), 32'd1);
        cyc(0, 1, 0, 0);
        check("abort keeps cnt", 32'(match_cnt), 32'd3);

        // Non-overlap: single match
        begin_session(8'b1111, 4, 0, 0, 0);
        feed(32'b0011111101, 10);
        check("nonoverlap match_cnt", 32'(match_cnt), 32'd1);
        cyc(0, 1, 0, 0);

        // Limit 2: ends on the second match, trailing bits ignored
        begin_session(8'b1111, 4, 1, 2, 0);
        feed(32'b0011111101, 10);
        check("limit done", 32'({done, busy, timeout}), 32'b100);
        check("limit match_cnt", 32'(match_cnt), 32'd2);

        // Window 5 with gaps in w_valid: timeout, no matches
        begin_session(8'b101, 3, 1, 0, 5);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 1);
            cyc(0, 0, 0, 0);
        end
        check("window done+timeout", 32'({done, timeout}), 32'b11);
        check("window match_cnt", 32'(match_cnt), 32'd0);

        // Abort after one match, then start+abort together from IDLE
        begin_session(8'b1111, 4, 1, 0, 0);
        feed(32'b11110, 5);
        cyc(0, 1, 1, 1);
        check("abort idle", 32'({busy, done}), 32'b00);
        check("abort cnt", 32'(match_cnt), 32'd1);
        cyc(1, 1, 0, 0);
        check("start+abort idle", 32'(busy), 32'd0);

        // Length clamp: 15 behaves as 8
        begin_session(8'hA5, 15, 0, 0, 0);
        feed(32'hA5, 8);
        check("clamp match", 32'(match_cnt), 32'd1);
        cyc(0, 1, 0, 0);

        // Saturating count: single-bit pattern, 260 ones
        begin_session(8'h01, 1, 1, 0, 0);
        for (int i = 0; i < 260; i++) cyc(0, 0, 1, 1);
        check("saturate", 32'(match_cnt), 32'd255);
        cyc(0, 1, 0, 0);

        // Reset mid-FILL, then a normal session
        begin_session(8'b1111, 4, 1, 0, 0);
        feed(32'b11, 2);
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("async reset outputs", 32'({z, busy, done, timeout, match_cnt}), 32'd0);
        cyc(1, 0, 1, 1);
        @(negedge clk);
        rst = 1'b1;
        begin_session(8'b1111, 4, 1, 0, 0);
        feed(32'b1111, 4);
        check("post-reset match", 32'(match_cnt), 32'd1);
        cyc(0, 1, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit st, ab, wv, wb;
            scramble_cfg();
            if ($urandom_range(0, 99) < 80) cfg_len = LEN_W'($urandom_range(0, 3));
            st = ($urandom_range(0, 99) < 8);
            ab = ($urandom_range(0, 99) < 2);
            wv = ($urandom_range(0, 99) < 75);
            wb = 1'($urandom);
            cyc(st, ab, wv, wb);
        end

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable controller that arms, runs and terminates serial bit-pattern detection sessions on a single-bit input stream. It sits between a configuration/host side (pattern, length, overlap mode, match limit, window) and the serial input `w`, owning the shift history and match comparator. It reports matches as a one-cycle `z` pulse, keeps a saturating match count, and ends a session on match-limit, window exhaustion or abort.

## Interface
Parameters:
- `MAX_LEN`, 8: maximum pattern length in bits (2..16).
- `CNT_W`, 8: width of match counter and `cfg_limit`.
- `WIN_W`, 16: width of window counter and `cfg_window`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_pattern`  in  MAX_LEN  pattern; bit 0 = most recent bit, bit len-1 = oldest.
- `cfg_len`  in  $clog2(MAX_LEN+1)  pattern length; 0 treated as 1, >MAX_LEN clamped to MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping matches, 0 = history cleared after each match.
- `cfg_limit`  in  CNT_W  session ends after this many matches; 0 = no limit.
- `cfg_window`  in  WIN_W  session ends after this many accepted bits; 0 = no limit.
- `start`  in  1  one-cycle session start request.
- `abort`  in  1  one-cycle session cancel.
- `w`  in  1  serial data bit.
- `w_valid`  in  1  `w` is sampled only when high.
- `z`  out  1  one-cycle match pulse.
- `busy`  out  1  session in progress (FILL or RUN).
- `done`  out  1  high while in DONE.
- `timeout`  out  1  session ended by window exhaustion without reaching the limit.
- `match_cnt`  out  CNT_W  matches in current/last session, saturating at all-ones.

## Operation
- States: IDLE, FILL, RUN, DONE.
- IDLE/DONE + `start`: latch all `cfg_*` (effective len after clamp), clear history, fill count, window count, `match_cnt`, `timeout`; go FILL. `cfg_*` changes during a session are ignored.
- FILL: each accepted bit (`w_valid`=1) shifts into history (new bit at bit 0), fill count +1, window count +1; when fill count reaches len (on that same bit), compare and go RUN.
- RUN: each accepted bit shifts and compares history[len-1:0] against cfg_pattern[len-1:0].
- Match: `z`=1 next cycle, `match_cnt`+1 (saturating). Non-overlap: fill count cleared, state returns to FILL. Overlap: stays RUN.
- Termination, evaluated on the accepted bit, priority order: (1) `match_cnt` reaches nonzero limit -> DONE, `timeout`=0; (2) window count reaches nonzero `cfg_window` -> DONE, `timeout`=1. A match on the final window bit is counted.
- `start` while busy: ignored. `abort` in FILL/RUN: IDLE next cycle, `done`=0, `match_cnt` held. `abort` and `start` same cycle: abort wins. `abort` in IDLE/DONE: DONE goes to IDLE, else no effect.
- Cycles with `w_valid`=0: no shift, no count change, no `z`.

## Timing
- Reset values: state IDLE, `z`=0, `busy`=0, `done`=0, `timeout`=0, `match_cnt`=0, history 0.
- `start` at edge t -> `busy`=1 after t; first bit accepted at edge t+1.
- Bit completing a match accepted at edge k -> `z`, `match_cnt` update visible after edge k (registered, one-cycle latency from sample).
- Limit/window termination on bit at edge k -> `done`=1, `busy`=0, final `z`/`match_cnt`/`timeout` all visible after edge k, simultaneously.
- Back-to-back `w_valid` every cycle supported; overlap mode can produce `z` on consecutive cycles.
- Reset mid-session: immediate return to reset values, no `done`.

## Structure
- Package `seq_ctrl_pkg`: state enum (IDLE, FILL, RUN, DONE), helper for len clamp, default width constants.
- Sub-module `seq_match_core`: history shift register, fill counter, masked comparator; inputs shift-enable, clear, len, pattern; output match. FSM, counters and termination logic in `seq_detect_ctrl`.

## Test plan
- Pattern 4'b1111, len 4, overlap, no limit/window; bits 0,0,1,1,1,1,1,1,0,1 -> `z` after 4th, 5th, 6th `1`; `match_cnt`=3; stays busy.
- Same stream, non-overlap -> single `z` after 4th `1`; `match_cnt`=1.
- Overlap, limit 2 -> `done`=1, `busy`=0 with second `z`; following bits ignored; `match_cnt`=2, `timeout`=0.
- Pattern 3'b101, window 5, bits 1,1,1,1,1 -> no `z`; `done`=1, `timeout`=1 after 5th bit; with gaps in `w_valid`, only valid bits count.
- Abort mid-RUN after 1 match -> IDLE, `done`=0, `match_cnt`=1; `start`+`abort` same cycle from IDLE -> stays IDLE.
- Assert `rst` low mid-FILL -> all outputs 0 immediately; subsequent `start` runs normally.
